// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: valid/ready request/response bus between the memory stage
// (master) and the data-memory responder (slave).
//   req_valid/req_ready  request handshake
//   req_write            1 = store, 0 = load
//   req_addr             byte address
//   req_wdata/req_be     store data and per-byte enables
//   resp_valid/resp_ready response handshake
//   resp_rdata           load data (0 for stores and errors)
//   resp_error           misaligned or out-of-range access
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the data-memory interface. Accepts one load/store
// at a time, performs the array access at the accept edge and presents the response a
// fixed LATENCY edges later; stall_m holds the pipeline while an access is outstanding.
// Ports:
//   clock    single clock, rising edge
//   reset    asynchronous, active-high
//   bus      data_mem_responder_if.slave request/response bus
//   stall_m  to hazard unit: request blocked or access outstanding
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  data_mem_responder_if.slave        bus,
  output logic                       stall_m
);

  localparam int unsigned AddrW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} stateT;

  stateT       stateQ, stateD;
  logic [3:0]  cntQ, cntD;
  logic [31:0] rdataQ;
  logic        errQ;
  logic [31:0] mem [DEPTH_WORDS];

  logic             accept;
  logic             consume;
  logic             addrErr;
  logic [AddrW-1:0] wordIdx;

  // Accept is suppressed while reset is held so nothing reaches the array during reset.
  assign accept  = bus.req_valid & (stateQ == StIdle) & ~reset;
  assign consume = (stateQ == StResp) & bus.resp_ready;
  assign addrErr = (bus.req_addr[1:0] != 2'b00) ||
                   ({2'b00, bus.req_addr[31:2]} >= DEPTH_WORDS);
  assign wordIdx = bus.req_addr[AddrW+1:2];

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ <= StIdle;
      cntQ   <= 4'd0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // Next-state logic. cntQ holds the number of WAIT edges already taken; the edge with
  // cntQ == LATENCY-1 is the LATENCY-th edge after accept.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    unique case (stateQ)
      StIdle: begin
        if (accept) begin
          cntD   = 4'd0;
          stateD = (LATENCY <= 1) ? StResp : StWait;
        end
      end
      StWait: begin
        if (cntQ == 4'(LATENCY - 1)) begin
          stateD = StResp;
          cntD   = 4'd0;
        end else begin
          cntD = cntQ + 4'd1;
        end
      end
      StResp: begin
        if (bus.resp_ready) stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    bus.req_ready  = (stateQ == StIdle);
    bus.resp_valid = (stateQ == StResp);
    bus.resp_rdata = rdataQ;
    bus.resp_error = errQ;
    stall_m        = (bus.req_valid & (stateQ != StIdle)) | (stateQ != StIdle);
  end

  // Response register: captured at accept, cleared once the response is consumed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdataQ <= 32'd0;
      errQ   <= 1'b0;
    end else if (accept) begin
      errQ   <= addrErr;
      rdataQ <= (!addrErr && !bus.req_write) ? mem[wordIdx] : 32'd0;
    end else if (consume) begin
      rdataQ <= 32'd0;
      errQ   <= 1'b0;
    end
  end

  // Array is deliberately not reset; stores commit at the accept edge.
  always_ff @(posedge clock) begin
    if (accept && bus.req_write && !addrErr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.req_be[b]) mem[wordIdx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic clock = 1'b0;
  logic reset;
  logic stall0, stall1;

  always #5 clock = ~clock;

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut0 (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus0),
    .stall_m(stall0)
  );

  data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus1),
    .stall_m(stall1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] expRdata;
    logic        expErr;
  } vecT;

  vecT vecs[21];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic vecT mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input logic [31:0] expR, input logic expE);
    vecT v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be; v.expRdata = expR; v.expErr = expE;
    return v;
  endfunction

  // Drive idle-cycle garbage so ignored inputs are exercised.
  task automatic idleBus0();
    bus0.req_valid = 1'b0;
    bus0.req_write = 1'b1;
    bus0.req_addr  = 32'hFFFF_FFFF;
    bus0.req_wdata = 32'h0;
    bus0.req_be    = 4'hF;
  endtask

  // Waits (bounded) for resp_valid on bus0; returns edges elapsed since the accept edge.
  task automatic waitResp0(output int lat, output logic got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      got = bus0.resp_valid;
    end
  endtask

  // One full transaction on dut0 with resp_ready held high.
  task automatic xact0(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] expR, input logic expE);
    int   lat;
    logic got;
    @(negedge clock);
    bus0.req_valid = 1'b1;
    bus0.req_write = wr;
    bus0.req_addr  = addr;
    bus0.req_wdata = wdata;
    bus0.req_be    = be;
    chk1({tag, " req_ready"}, bus0.req_ready, 1'b1);
    @(posedge clock);
    #1 idleBus0();
    waitResp0(lat, got);
    chk1({tag, " resp_valid"}, got, 1'b1);
    chk32({tag, " latency"}, 32'(lat), 32'd2);
    chk32({tag, " rdata"}, bus0.resp_rdata, expR);
    chk1({tag, " error"}, bus0.resp_error, expE);
    chk1({tag, " stall"}, stall0, 1'b1);
    @(posedge clock);
    @(negedge clock);
    chk1({tag, " post valid"}, bus0.resp_valid, 1'b0);
    chk32({tag, " post rdata"}, bus0.resp_rdata, 32'd0);
    chk1({tag, " post error"}, bus0.resp_error, 1'b0);
    chk1({tag, " post ready"}, bus0.req_ready, 1'b1);
  endtask

  initial begin
    int      lat;
    logic    got;
    int      seen;
    longint  prevT;
    logic [31:0] exp6;
    logic        err6;

    vecs[0]  = mk(1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
    vecs[1]  = mk(1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
    vecs[2]  = mk(1'b1, 32'h20,       32'hFFFFFFFF, 4'hF, 32'h0,        1'b0);
    vecs[3]  = mk(1'b1, 32'h20,       32'h1234ABCD, 4'h3, 32'h0,        1'b0);
    vecs[4]  = mk(1'b0, 32'h20,       32'h0,        4'h0, 32'hFFFFABCD, 1'b0);
    vecs[5]  = mk(1'b0, 32'h22,       32'h0,        4'h0, 32'h0,        1'b1);
    vecs[6]  = mk(1'b0, 32'h1000,     32'h0,        4'h0, 32'h0,        1'b1);
    vecs[7]  = mk(1'b1, 32'h22,       32'h00000000, 4'hF, 32'h0,        1'b1);
    vecs[8]  = mk(1'b0, 32'h20,       32'h0,        4'h0, 32'hFFFFABCD, 1'b0);
    vecs[9]  = mk(1'b0, 32'h11,       32'h0,        4'h0, 32'h0,        1'b1);
    vecs[10] = mk(1'b0, 32'h80000000, 32'h0,        4'h0, 32'h0,        1'b1);
    vecs[11] = mk(1'b1, 32'h24,       32'h11223344, 4'hF, 32'h0,        1'b0);
    vecs[12] = mk(1'b1, 32'h24,       32'h55667788, 4'h0, 32'h0,        1'b0);
    vecs[13] = mk(1'b0, 32'h24,       32'h0,        4'h0, 32'h11223344, 1'b0);
    vecs[14] = mk(1'b1, 32'h10,       32'hAABBCCDD, 4'hA, 32'h0,        1'b0);
    vecs[15] = mk(1'b0, 32'h10,       32'h0,        4'h0, 32'hAAADCCEF, 1'b0);
    vecs[16] = mk(1'b1, 32'hFFC,      32'hCAFEF00D, 4'hF, 32'h0,        1'b0);
    vecs[17] = mk(1'b0, 32'hFFC,      32'h0,        4'h0, 32'hCAFEF00D, 1'b0);
    vecs[18] = mk(1'b1, 32'h0,        32'h00000000, 4'hF, 32'h0,        1'b0);
    vecs[19] = mk(1'b1, 32'h1000,     32'h12345678, 4'hF, 32'h0,        1'b1);
    vecs[20] = mk(1'b0, 32'h0,        32'h0,        4'h0, 32'h00000000, 1'b0);

    reset = 1'b1;
    idleBus0();
    bus0.resp_ready = 1'b1;
    bus1.req_valid  = 1'b0;
    bus1.req_write  = 1'b0;
    bus1.req_addr   = 32'h0;
    bus1.req_wdata  = 32'h0;
    bus1.req_be     = 4'h0;
    bus1.resp_ready = 1'b1;

    // Reset values
    #12;
    chk1("rst req_ready", bus0.req_ready, 1'b1);
    chk1("rst resp_valid", bus0.resp_valid, 1'b0);
    chk32("rst rdata", bus0.resp_rdata, 32'd0);
    chk1("rst error", bus0.resp_error, 1'b0);
    chk1("rst stall", stall0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk1("idle stall", stall0, 1'b0);
    chk1("idle resp_valid", bus0.resp_valid, 1'b0);

    // Directed table
    for (int i = 0; i < 21; i++) begin
      xact0($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
            vecs[i].expRdata, vecs[i].expErr);
    end

    // Back-pressure with a second request pending
    @(negedge clock);
    bus0.resp_ready = 1'b0;
    bus0.req_valid  = 1'b1;
    bus0.req_write  = 1'b0;
    bus0.req_addr   = 32'h10;
    @(posedge clock);
    #1 idleBus0();
    waitResp0(lat, got);
    chk1("bp resp_valid", got, 1'b1);
    chk32("bp latency", 32'(lat), 32'd2);
    bus0.req_valid = 1'b1;
    bus0.req_write = 1'b0;
    bus0.req_addr  = 32'h20;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk1($sformatf("bp hold%0d valid", k), bus0.resp_valid, 1'b1);
      chk32($sformatf("bp hold%0d rdata", k), bus0.resp_rdata, 32'hAAADCCEF);
      chk1($sformatf("bp hold%0d error", k), bus0.resp_error, 1'b0);
      chk1($sformatf("bp hold%0d req_ready", k), bus0.req_ready, 1'b0);
      chk1($sformatf("bp hold%0d stall", k), stall0, 1'b1);
    end
    bus0.resp_ready = 1'b1;
    @(posedge clock);
    #1 bus0.resp_ready = 1'b0;
    @(negedge clock);
    chk1("bp released ready", bus0.req_ready, 1'b1);
    chk1("bp released valid", bus0.resp_valid, 1'b0);
    chk1("bp released stall", stall0, 1'b0);
    @(posedge clock);
    #1 idleBus0();
    waitResp0(lat, got);
    chk1("bp second valid", got, 1'b1);
    chk32("bp second latency", 32'(lat), 32'd2);
    chk32("bp second rdata", bus0.resp_rdata, 32'hFFFFABCD);
    bus0.resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk1("bp second consumed", bus0.resp_valid, 1'b0);

    // Reset while waiting on an accepted store
    @(negedge clock);
    bus0.req_valid = 1'b1;
    bus0.req_write = 1'b1;
    bus0.req_addr  = 32'h30;
    bus0.req_wdata = 32'h0BADCAFE;
    bus0.req_be    = 4'hF;
    @(posedge clock);
    #1 idleBus0();
    @(negedge clock);
    chk1("wait stall", stall0, 1'b1);
    chk1("wait req_ready", bus0.req_ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk1("mid rst req_ready", bus0.req_ready, 1'b1);
    chk1("mid rst valid", bus0.resp_valid, 1'b0);
    chk32("mid rst rdata", bus0.resp_rdata, 32'd0);
    chk1("mid rst error", bus0.resp_error, 1'b0);
    chk1("mid rst stall", stall0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (bus0.resp_valid === 1'b1) seen++;
    end
    chk32("post rst no resp", 32'(seen), 32'd0);
    xact0("post rst load", 1'b0, 32'h30, 32'h0, 4'h0, 32'h0BADCAFE, 1'b0);

    // LATENCY=1 instance: one transaction per 3 cycles
    prevT = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clock);
      #1;
      bus1.req_valid = 1'b1;
      if (i < 4) begin
        bus1.req_write = 1'b1;
        bus1.req_addr  = 32'(4 * i);
        bus1.req_wdata = 32'hA5000000 + 32'(i);
        bus1.req_be    = 4'hF;
        exp6 = 32'h0;
        err6 = 1'b0;
      end else if (i < 8) begin
        bus1.req_write = 1'b0;
        bus1.req_addr  = 32'(4 * (i - 4));
        exp6 = 32'hA5000000 + 32'(i - 4);
        err6 = 1'b0;
      end else begin
        bus1.req_write = 1'b0;
        bus1.req_addr  = 32'h40;
        exp6 = 32'h0;
        err6 = 1'b1;
      end
      @(negedge clock);
      chk1($sformatf("l1 t%0d ready", i), bus1.req_ready, 1'b1);
      @(posedge clock);
      #1 bus1.req_valid = 1'b0;
      @(negedge clock);
      chk1($sformatf("l1 t%0d valid", i), bus1.resp_valid, 1'b1);
      chk32($sformatf("l1 t%0d rdata", i), bus1.resp_rdata, exp6);
      chk1($sformatf("l1 t%0d error", i), bus1.resp_error, err6);
      chk1($sformatf("l1 t%0d stall", i), stall1, 1'b1);
      if (i > 0) chk32($sformatf("l1 t%0d cadence", i), 32'($time - prevT), 32'd30);
      prevT = $time;
      @(posedge clock);
      @(negedge clock);
      chk1($sformatf("l1 t%0d idle valid", i), bus1.resp_valid, 1'b0);
      chk1($sformatf("l1 t%0d idle stall", i), stall1, 1'b0);
      chk1($sformatf("l1 t%0d idle ready", i), bus1.req_ready, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
